// File: rtl/dadd.sv
// Data-add stage: each enabled beat is delayed by LATENCY clocks with
// ADD_VAL added to its data and its address passed through unchanged.
module dadd #(
  parameter int unsigned DW      = 32,
  parameter int unsigned AW      = 32,
  parameter int unsigned ADD_VAL = 1,
  parameter int unsigned LATENCY = 1
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          dadd_in_en,
  input  logic [AW-1:0] dadd_in_addr,
  input  logic [DW-1:0] dadd_in,
  output logic          dadd_out_en,
  output logic [AW-1:0] dadd_out_addr,
  output logic [DW-1:0] dadd_out
);

  localparam int unsigned LAST = LATENCY - 1;

  if ((LATENCY < 1) || (LATENCY > 8)) begin : g_bad_latency
    $error("dadd: LATENCY must be in the range 1..8");
  end

  typedef struct packed {
    logic          vld;
    logic [AW-1:0] addr;
    logic [DW-1:0] data;
  } beat_t;

  beat_t r_stage [LATENCY];
  beat_t w_capture;

  // Idle cycles load an all-zero beat so stale data never reaches the outputs.
  always_comb begin
    w_capture = '0;
    if (dadd_in_en) begin
      w_capture.vld  = 1'b1;
      w_capture.addr = dadd_in_addr;
      w_capture.data = dadd_in + DW'(ADD_VAL);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < LATENCY; i++) begin
        r_stage[i] <= '0;
      end
    end else begin
      r_stage[0] <= w_capture;
      for (int unsigned i = 1; i < LATENCY; i++) begin
        r_stage[i] <= r_stage[i-1];
      end
    end
  end

  assign dadd_out_en   = r_stage[LAST].vld;
  assign dadd_out_addr = r_stage[LAST].addr;
  assign dadd_out      = r_stage[LAST].data;

endmodule

// File: tb/tb_dadd.sv
// Bench for dadd: three instances (latency 1, 4 and 3/+5) against a
// sample-history model, plus directed literal checks.
module tb_dadd;

  typedef struct packed {
    logic        en;
    logic [31:0] addr;
    logic [31:0] data;
  } beat_t;

  logic        clk;
  logic        rst_n;
  logic        in_en;
  logic [31:0] in_addr;
  logic [31:0] in_data;

  logic        o1_en, o4_en, o3_en;
  logic [31:0] o1_addr, o4_addr, o3_addr;
  logic [31:0] o1_data, o4_data, o3_data;

  int checks = 0;
  int errors = 0;

  dadd #(.DW(32), .AW(32), .ADD_VAL(1), .LATENCY(1)) u_l1 (
    .clk(clk), .rst_n(rst_n), .dadd_in_en(in_en), .dadd_in_addr(in_addr),
    .dadd_in(in_data), .dadd_out_en(o1_en), .dadd_out_addr(o1_addr), .dadd_out(o1_data));

  dadd #(.DW(32), .AW(32), .ADD_VAL(1), .LATENCY(4)) u_l4 (
    .clk(clk), .rst_n(rst_n), .dadd_in_en(in_en), .dadd_in_addr(in_addr),
    .dadd_in(in_data), .dadd_out_en(o4_en), .dadd_out_addr(o4_addr), .dadd_out(o4_data));

  dadd #(.DW(32), .AW(32), .ADD_VAL(5), .LATENCY(3)) u_l3 (
    .clk(clk), .rst_n(rst_n), .dadd_in_en(in_en), .dadd_in_addr(in_addr),
    .dadd_in(in_data), .dadd_out_en(o3_en), .dadd_out_addr(o3_addr), .dadd_out(o3_data));

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h at %0t", nm, act, exp, $time);
    end
  endtask

  // Model: most recent sampled beat first; output of a depth-L stage is the
  // beat sampled L-1 edges ago, or nothing if reset intervened since then.
  beat_t q1[$];
  beat_t q4[$];
  beat_t q3[$];

  function automatic beat_t mk(input logic [31:0] add);
    beat_t b;
    b = '0;
    if (in_en) begin
      b.en   = 1'b1;
      b.addr = in_addr;
      b.data = in_data + add;
    end
    return b;
  endfunction

  function automatic beat_t exp_of(input beat_t q[$], input int l);
    beat_t z;
    z = '0;
    if (!rst_n || q.size() < l) return z;
    return q[l-1];
  endfunction

  always @(posedge clk) begin
    if (!rst_n) begin
      q1.delete();
      q4.delete();
      q3.delete();
    end else begin
      q1.push_front(mk(32'd1));
      q4.push_front(mk(32'd1));
      q3.push_front(mk(32'd5));
      if (q1.size() > 8) void'(q1.pop_back());
      if (q4.size() > 8) void'(q4.pop_back());
      if (q3.size() > 8) void'(q3.pop_back());
    end
  end

  always @(negedge clk) begin
    beat_t e1, e4, e3;
    e1 = exp_of(q1, 1);
    e4 = exp_of(q4, 4);
    e3 = exp_of(q3, 3);
    chk("m_l1_en",   32'(o1_en), 32'(e1.en));
    chk("m_l1_addr", o1_addr,    e1.addr);
    chk("m_l1_data", o1_data,    e1.data);
    chk("m_l4_en",   32'(o4_en), 32'(e4.en));
    chk("m_l4_addr", o4_addr,    e4.addr);
    chk("m_l4_data", o4_data,    e4.data);
    chk("m_l3_en",   32'(o3_en), 32'(e3.en));
    chk("m_l3_addr", o3_addr,    e3.addr);
    chk("m_l3_data", o3_data,    e3.data);
  end

  // Drive the beat that the next rising edge will sample.
  task automatic step(input logic en, input logic [31:0] a, input logic [31:0] d);
    @(posedge clk);
    #1;
    in_en   = en;
    in_addr = a;
    in_data = d;
  endtask

  initial begin
    rst_n   = 1'b0;
    in_en   = 1'($urandom);
    in_addr = $urandom;
    in_data = $urandom;
    repeat (2) begin
      @(negedge clk);
      #1;
      chk("rst_l1_en",   32'(o1_en), 32'd0);
      chk("rst_l1_data", o1_data,    32'd0);
      chk("rst_l4_addr", o4_addr,    32'd0);
      in_en   = 1'($urandom);
      in_addr = $urandom;
      in_data = $urandom;
    end
    @(negedge clk);
    #2;
    rst_n   = 1'b1;
    in_en   = 1'b0;
    in_addr = '0;
    in_data = '0;

    // Single beats separated by an idle cycle
    step(1'b1, 32'd1, 32'd1);
    step(1'b0, 32'd0, 32'd0);
    chk("s1_en", 32'(o1_en), 32'd1);
    chk("s1_data", o1_data, 32'd2);
    chk("s1_addr", o1_addr, 32'd1);
    step(1'b1, 32'd2, 32'd2);
    chk("s_gap_en", 32'(o1_en), 32'd0);
    chk("s_gap_data", o1_data, 32'd0);
    step(1'b0, 32'd0, 32'd0);
    chk("s2_en", 32'(o1_en), 32'd1);
    chk("s2_data", o1_data, 32'd3);
    chk("s2_addr", o1_addr, 32'd2);
    step(1'b0, 32'd0, 32'd0);
    chk("s_after_en", 32'(o1_en), 32'd0);

    // Back-to-back beats
    for (int i = 0; i <= 6; i++) begin
      if (i < 4) step(1'b1, 32'h100 + 32'(i), 32'd10 + 32'(i));
      else       step(1'b0, 32'd0, 32'd0);
      if (i >= 1 && i <= 4) begin
        chk("b2b_l1_en", 32'(o1_en), 32'd1);
        chk("b2b_l1_data", o1_data, 32'd10 + 32'(i));
        chk("b2b_l1_addr", o1_addr, 32'h100 + 32'(i - 1));
      end else if (i > 4) begin
        chk("b2b_l1_idle", 32'(o1_en), 32'd0);
      end
      if (i >= 3) begin
        chk("b2b_l3_data", o3_data, 32'd15 + 32'(i - 3));
        chk("b2b_l3_addr", o3_addr, 32'h100 + 32'(i - 3));
      end
    end

    // Carry-out is discarded
    step(1'b1, 32'hDEADBEEF, 32'hFFFFFFFF);
    step(1'b0, 32'd0, 32'd0);
    chk("wrap_l1_en", 32'(o1_en), 32'd1);
    chk("wrap_l1_data", o1_data, 32'h00000000);
    chk("wrap_l1_addr", o1_addr, 32'hDEADBEEF);
    step(1'b0, 32'd0, 32'd0);
    step(1'b0, 32'd0, 32'd0);
    chk("wrap_l3_data", o3_data, 32'd4);
    chk("wrap_l3_addr", o3_addr, 32'hDEADBEEF);
    step(1'b0, 32'd0, 32'd0);

    // Latency 3 / add 5: single-cycle pulse exactly on the third edge
    step(1'b1, 32'h55, 32'd7);
    step(1'b0, 32'd0, 32'd0);
    chk("p3_e0_en", 32'(o3_en), 32'd0);
    step(1'b0, 32'd0, 32'd0);
    chk("p3_e1_en", 32'(o3_en), 32'd0);
    step(1'b0, 32'd0, 32'd0);
    chk("p3_e2_en", 32'(o3_en), 32'd1);
    chk("p3_e2_data", o3_data, 32'd12);
    chk("p3_e2_addr", o3_addr, 32'h55);
    step(1'b0, 32'd0, 32'd0);
    chk("p3_e3_en", 32'(o3_en), 32'd0);
    repeat (4) step(1'b0, 32'd0, 32'd0);

    // Reset while three beats are in flight in the latency-4 instance
    step(1'b1, 32'hA0, 32'h20);
    step(1'b1, 32'hA1, 32'h21);
    step(1'b1, 32'hA2, 32'h22);
    step(1'b0, 32'd0, 32'd0);
    chk("mr_pre_l4_en", 32'(o4_en), 32'd0);
    chk("mr_pre_l1_en", 32'(o1_en), 32'd1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("mr_l1_en", 32'(o1_en), 32'd0);
    chk("mr_l1_data", o1_data, 32'd0);
    chk("mr_l3_data", o3_data, 32'd0);
    chk("mr_l4_en", 32'(o4_en), 32'd0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    #2;
    rst_n = 1'b1;
    repeat (6) begin
      step(1'b0, 32'd0, 32'd0);
      chk("mr_post_l4_en", 32'(o4_en), 32'd0);
      chk("mr_post_l4_data", o4_data, 32'd0);
    end

    repeat (2) @(negedge clk);
    #1;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
